// File: rtl/pp_row_reader.sv
// Row-burst reader for the preprocess output FIFO: pulls one LINE_WIDTH row per grant
// and re-times it into a framed pixel stream with line/frame markers.
module pp_row_reader #(
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned LINE_WIDTH   = 640,
  parameter int unsigned FRAME_HEIGHT = 480
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  output logic                  o_rd,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  input  logic                  i_empty,
  input  logic                  i_row_req,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_sol,
  output logic                  o_eol,
  output logic                  o_sof,
  output logic                  o_eof,
  output logic                  o_row_done,
  output logic                  o_busy,
  output logic                  o_overflow
);

  localparam int unsigned CW = $clog2(LINE_WIDTH + 1);
  localparam int unsigned RW = $clog2(FRAME_HEIGHT);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBurst = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [CW-1:0] ColLast = CW'(LINE_WIDTH - 1);
  localparam logic [CW-1:0] ColFull = CW'(LINE_WIDTH);
  localparam logic [RW-1:0] RowLast = RW'(FRAME_HEIGHT - 1);

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         issued_q, issued_d;
  logic [CW-1:0]         received_q, received_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q, sol_q, eol_q, sof_q, eof_q, overflow_q;
  logic                  accept;

  assign o_rd = (state_q == StBurst) && !i_empty && (issued_q < ColFull);

  // A pixel is only taken when a read is outstanding; anything else is a stray beat.
  assign accept = i_valid && (issued_q != received_q);

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    received_d = received_q;
    row_d      = row_q;
    case (state_q)
      StIdle: begin
        if (i_row_req) begin
          state_d    = StBurst;
          issued_d   = '0;
          received_d = '0;
        end
      end
      StBurst: begin
        if (o_rd) begin
          issued_d = issued_q + CW'(1);
        end
        if (accept) begin
          received_d = received_q + CW'(1);
        end
        if (received_q == ColFull) begin
          state_d = StDone;
        end
      end
      StDone: begin
        row_d   = (row_q == RowLast) ? '0 : row_q + RW'(1);
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q    <= StIdle;
      issued_q   <= '0;
      received_q <= '0;
      row_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      sol_q      <= 1'b0;
      eol_q      <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      row_q      <= row_d;
      if (accept) begin
        data_q <= i_data;
      end
      valid_q    <= accept;
      sol_q      <= accept && (received_q == '0);
      eol_q      <= accept && (received_q == ColLast);
      sof_q      <= accept && (received_q == '0) && (row_q == '0);
      eof_q      <= accept && (received_q == ColLast) && (row_q == RowLast);
      overflow_q <= overflow_q || (i_valid && !accept);
    end
  end

  assign o_data     = data_q;
  assign o_valid    = valid_q;
  assign o_sol      = sol_q;
  assign o_eol      = eol_q;
  assign o_sof      = sof_q;
  assign o_eof      = eof_q;
  assign o_row_done = (state_q == StDone);
  assign o_busy     = (state_q != StIdle);
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_pp_row_reader.sv
// Bench for pp_row_reader: a FIFO read-port model feeds random pixels, and output beats
// are compared against a row/column position model of the framed stream.
module tb_pp_row_reader;

  localparam int DW = 12;
  localparam int LW = 8;
  localparam int FH = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [3:0]    mk;   // {sol, eol, sof, eof}
    int            cyc;
  } beat_t;

  logic          clk = 1'b0;
  logic          rstn;
  logic          o_rd;
  logic [DW-1:0] i_data;
  logic          i_valid, i_empty, i_row_req;
  logic [DW-1:0] o_data;
  logic          o_valid, o_sol, o_eol, o_sof, o_eof, o_row_done, o_busy, o_overflow;

  pp_row_reader #(
    .DATA_WIDTH  (DW),
    .LINE_WIDTH  (LW),
    .FRAME_HEIGHT(FH)
  ) dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .o_rd      (o_rd),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .i_empty   (i_empty),
    .i_row_req (i_row_req),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_sol     (o_sol),
    .o_eol     (o_eol),
    .o_sof     (o_sof),
    .o_eof     (o_eof),
    .o_row_done(o_row_done),
    .o_busy    (o_busy),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  beat_t         beats[$];
  int            rd_cyc[$];
  int            done_cyc[$];
  bit            busy_log[$];
  logic [DW-1:0] sent_q[$];
  int            cyc = 0;
  int            log_base = 0;
  bit            pend_rd = 1'b0;
  int            rd_empty_viol = 0;
  int            rd_idle_viol = 0;
  int            exp_row = 0;
  int            n_checks = 0;
  int            n_pass = 0;

  function automatic logic [3:0] exp_mk(input int col, input int row);
    logic sol, eol;
    sol = (col == 0);
    eol = (col == LW - 1);
    return {sol, eol, sol && (row == 0), eol && (row == FH - 1)};
  endfunction

  // One clock of the upstream FIFO port: data follows an accepted read by one cycle.
  task automatic cycle(input bit empty, input bit req, input bit inj);
    bit    rd_now;
    beat_t b;
    i_empty   = empty;
    i_row_req = req;
    i_valid   = pend_rd | inj;
    i_data    = DW'($urandom);
    if (pend_rd && rstn) sent_q.push_back(i_data);
    @(negedge clk);
    if (o_valid) begin
      b.data = o_data;
      b.mk   = {o_sol, o_eol, o_sof, o_eof};
      b.cyc  = cyc;
      beats.push_back(b);
    end
    if (o_row_done) done_cyc.push_back(cyc);
    busy_log.push_back(o_busy);
    rd_now = o_rd && rstn;
    if (o_rd && rstn) begin
      rd_cyc.push_back(cyc);
      if (empty) rd_empty_viol++;
      if (!o_busy || o_row_done) rd_idle_viol++;
    end
    @(posedge clk);
    #1;
    pend_rd = rd_now;
    cyc++;
  endtask

  task automatic clear_logs();
    beats.delete();
    rd_cyc.delete();
    done_cyc.delete();
    busy_log.delete();
    sent_q.delete();
    rd_empty_viol = 0;
    rd_idle_viol  = 0;
    log_base      = cyc;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    rstn    = 1'b1;
    pend_rd = 1'b0;
    exp_row = 0;
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({o_valid, o_sol, o_eol, o_sof, o_eof, o_row_done, o_busy, o_overflow, o_rd} !== 9'd0)
      $display("FAIL reset_flags: got %b want 000000000",
               {o_valid, o_sol, o_eol, o_sof, o_eof, o_row_done, o_busy, o_overflow, o_rd});
    else n_pass++;
    n_checks++;
    if (o_data !== '0) $display("FAIL reset_data: got %0h want 0", o_data);
    else n_pass++;
  endtask

  task automatic test_single_row();
    int c0;
    clear_logs();
    c0 = cyc;
    cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rd_cyc.size() !== LW) $display("FAIL single_rd_count: got %0d want %0d", rd_cyc.size(), LW);
    else n_pass++;
    for (int k = 0; k < rd_cyc.size(); k++) begin
      n_checks++;
      if (rd_cyc[k] !== c0 + 1 + k)
        $display("FAIL single_rd_cycle %0d: got %0d want %0d", k, rd_cyc[k] - c0, 1 + k);
      else n_pass++;
    end
    n_checks++;
    if (beats.size() !== LW) $display("FAIL single_beats: got %0d want %0d", beats.size(), LW);
    else n_pass++;
    for (int i = 0; i < beats.size() && i < sent_q.size(); i++) begin
      n_checks++;
      if ({beats[i].data, beats[i].mk, beats[i].cyc} !==
          {sent_q[i], exp_mk(i, exp_row), c0 + 3 + i})
        $display("FAIL single_beat %0d: got d=%0h mk=%b t=%0d want d=%0h mk=%b t=%0d", i,
                 beats[i].data, beats[i].mk, beats[i].cyc - c0, sent_q[i], exp_mk(i, exp_row),
                 3 + i);
      else n_pass++;
    end
    n_checks++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== c0 + 3 + LW)
      $display("FAIL single_row_done: got n=%0d t=%0d want n=1 t=%0d", done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] - c0 : -1, 3 + LW);
    else n_pass++;
    exp_row = (exp_row + 1) % FH;
  endtask

  task automatic test_empty_gaps();
    int ph;
    clear_logs();
    ph = $urandom_range(0, 2);
    cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) cycle((((k + ph) / 3) % 2) == 1, 1'b0, 1'b0);
    n_checks++;
    if (rd_empty_viol !== 0) $display("FAIL gaps_rd_while_empty: got %0d want 0", rd_empty_viol);
    else n_pass++;
    n_checks++;
    if (rd_cyc.size() !== LW) $display("FAIL gaps_rd_count: got %0d want %0d", rd_cyc.size(), LW);
    else n_pass++;
    n_checks++;
    if (beats.size() !== LW) $display("FAIL gaps_beats: got %0d want %0d", beats.size(), LW);
    else n_pass++;
    for (int i = 0; i < beats.size() && i < sent_q.size(); i++) begin
      n_checks++;
      if ({beats[i].data, beats[i].mk} !== {sent_q[i], exp_mk(i, exp_row)})
        $display("FAIL gaps_beat %0d: got d=%0h mk=%b want d=%0h mk=%b", i, beats[i].data,
                 beats[i].mk, sent_q[i], exp_mk(i, exp_row));
      else n_pass++;
    end
    n_checks++;
    if (done_cyc.size() !== 1) $display("FAIL gaps_row_done: got %0d want 1", done_cyc.size());
    else n_pass++;
    exp_row = (exp_row + 1) % FH;
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    n = 0;
    while (done_cyc.size() < FH + 1 && n < 400) begin
      cycle($urandom_range(0, 3) == 0, !o_busy, 1'b0);
      n++;
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (done_cyc.size() !== FH + 1)
      $display("FAIL b2b_rows: got %0d want %0d", done_cyc.size(), FH + 1);
    else n_pass++;
    n_checks++;
    if (beats.size() !== LW * (FH + 1))
      $display("FAIL b2b_beats: got %0d want %0d", beats.size(), LW * (FH + 1));
    else n_pass++;
    n_checks++;
    if (rd_idle_viol !== 0) $display("FAIL b2b_rd_outside_burst: got %0d want 0", rd_idle_viol);
    else n_pass++;
    for (int i = 0; i < beats.size() && i < sent_q.size(); i++) begin
      n_checks++;
      if ({beats[i].data, beats[i].mk} !== {sent_q[i], exp_mk(i % LW, (exp_row + i / LW) % FH)})
        $display("FAIL b2b_beat %0d: got d=%0h mk=%b want d=%0h mk=%b", i, beats[i].data,
                 beats[i].mk, sent_q[i], exp_mk(i % LW, (exp_row + i / LW) % FH));
      else n_pass++;
    end
    exp_row = (exp_row + FH + 1) % FH;
  endtask

  task automatic test_overflow();
    clear_logs();
    n_checks++;
    if (o_overflow !== 1'b0) $display("FAIL ovf_initial: got %b want 0", o_overflow);
    else n_pass++;
    cycle(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (beats.size() !== 0) $display("FAIL ovf_no_valid: got %0d want 0", beats.size());
    else n_pass++;
    n_checks++;
    if ({o_overflow, o_busy} !== 2'b10) $display("FAIL ovf_sticky: got %b want 10",
                                                 {o_overflow, o_busy});
    else n_pass++;
  endtask

  task automatic test_reset_mid_row();
    int n;
    clear_logs();
    cycle(1'b0, 1'b1, 1'b0);
    n = 0;
    while (beats.size() < 3 && n < 20) begin
      cycle(1'b0, 1'b0, 1'b0);
      n++;
    end
    n_checks++;
    if (beats.size() !== 3) $display("FAIL midrst_reach_beat3: got %0d want 3", beats.size());
    else n_pass++;
    rstn = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    rstn    = 1'b1;
    pend_rd = 1'b0;
    n_checks++;
    if ({o_valid, o_sol, o_eol, o_sof, o_eof, o_row_done, o_busy, o_overflow, o_rd} !== 9'd0)
      $display("FAIL midrst_flags: got %b want 000000000",
               {o_valid, o_sol, o_eol, o_sof, o_eof, o_row_done, o_busy, o_overflow, o_rd});
    else n_pass++;
    n_checks++;
    if (o_data !== '0) $display("FAIL midrst_data: got %0h want 0", o_data);
    else n_pass++;
    exp_row = 0;
    clear_logs();
    cycle(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 16; k++) cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (beats.size() !== LW) $display("FAIL midrst_beats: got %0d want %0d", beats.size(), LW);
    else n_pass++;
    for (int i = 0; i < beats.size() && i < sent_q.size(); i++) begin
      n_checks++;
      if ({beats[i].data, beats[i].mk} !== {sent_q[i], exp_mk(i, 0)})
        $display("FAIL midrst_beat %0d: got d=%0h mk=%b want d=%0h mk=%b", i, beats[i].data,
                 beats[i].mk, sent_q[i], exp_mk(i, 0));
      else n_pass++;
    end
    exp_row = 1;
  endtask

  task automatic test_req_held();
    int n, cnt, lo;
    clear_logs();
    n = 0;
    while (done_cyc.size() < 3 && n < 300) begin
      cycle($urandom_range(0, 4) == 0, 1'b1, 1'b0);
      n++;
    end
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (done_cyc.size() !== 3 || rd_cyc.size() !== 3 * LW)
      $display("FAIL held_counts: got rows=%0d reads=%0d want rows=3 reads=%0d",
               done_cyc.size(), rd_cyc.size(), 3 * LW);
    else n_pass++;
    for (int r = 0; r < done_cyc.size(); r++) begin
      cnt = 0;
      lo  = (r == 0) ? log_base : done_cyc[r - 1];
      foreach (rd_cyc[j]) if (rd_cyc[j] > lo && rd_cyc[j] < done_cyc[r]) cnt++;
      n_checks++;
      if (cnt !== LW) $display("FAIL held_row_reads %0d: got %0d want %0d", r, cnt, LW);
      else n_pass++;
      n_checks++;
      if ({busy_log[done_cyc[r] - log_base], busy_log[done_cyc[r] + 1 - log_base]} !== 2'b10)
        $display("FAIL held_busy %0d: got %b want 10", r,
                 {busy_log[done_cyc[r] - log_base], busy_log[done_cyc[r] + 1 - log_base]});
      else n_pass++;
      if (r < 2 && rd_cyc.size() > LW * (r + 1)) begin
        n_checks++;
        if (rd_cyc[LW * (r + 1)] < done_cyc[r] + 2)
          $display("FAIL held_gap %0d: got %0d want >=2", r, rd_cyc[LW * (r + 1)] - done_cyc[r]);
        else n_pass++;
      end
    end
    for (int i = 0; i < beats.size() && i < sent_q.size(); i++) begin
      n_checks++;
      if ({beats[i].data, beats[i].mk} !== {sent_q[i], exp_mk(i % LW, (exp_row + i / LW) % FH)})
        $display("FAIL held_beat %0d: got d=%0h mk=%b want d=%0h mk=%b", i, beats[i].data,
                 beats[i].mk, sent_q[i], exp_mk(i % LW, (exp_row + i / LW) % FH));
      else n_pass++;
    end
    exp_row = (exp_row + 3) % FH;
  endtask

  initial begin
    rstn      = 1'b0;
    i_data    = '0;
    i_valid   = 1'b0;
    i_empty   = 1'b0;
    i_row_req = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_row();
    test_empty_gaps();
    test_back_to_back();
    test_overflow();
    test_reset_mid_row();
    test_req_held();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
